// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scanner.
package seg_pkg;

    localparam int          SEG_DIGITS = 4;
    localparam int          IDX_W      = 2;
    localparam logic [3:0]  ANODE_OFF  = 4'b1111;

    // Active-low one-hot anode pattern for digit slot idx.
    function automatic logic [3:0] anode_sel(input logic [IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-side bus of the scanner: value/load/blank in, nibble/anodes/ack out.
interface seg_scan_mux_if;

    logic [15:0] value;
    logic        load;
    logic        blank;
    logic [3:0]  nibble;
    logic [3:0]  T;
    logic        load_ack;

    modport master (
        output value, load, blank,
        input  nibble, T, load_ack
    );

    modport slave (
        input  value, load, blank,
        output nibble, T, load_ack
    );

endinterface

// File: rtl/seg_scan_tick.sv
// Digit-slot prescaler: cnt runs 0..DIV-1, tick is high on the last count.
module seg_scan_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_div_check
            $error("seg_scan_tick: DIV must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit time-multiplexed scanner for a common-anode seven-segment display.
// Optional leading-zero blanking is enabled with `define SEG_SCAN_MUX_LZB_EN.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_mux_if.slave  bus
);

    localparam int DIV = CLK_HZ / SCAN_HZ;

    logic             tick;
    logic [IDX_W-1:0] idx;
    logic [15:0]      shadow;
    logic [15:0]      pend_val;
    logic             pend;
    logic             commit;
    logic             lz_dark;
    logic [3:0]       nibble_r;
    logic [3:0]       t_r;
    logic             ack_r;

    seg_scan_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign commit = tick && (idx == 2'd3) && pend;

`ifdef SEG_SCAN_MUX_LZB_EN
    // A slot goes dark when it and every digit above it are zero; digit0 never does.
    always_comb begin
        lz_dark = 1'b0;
        case (idx)
            2'd3:    lz_dark = (shadow[15:12] == 4'h0);
            2'd2:    lz_dark = (shadow[15:8]  == 8'h00);
            2'd1:    lz_dark = (shadow[15:4]  == 12'h000);
            default: lz_dark = 1'b0;
        endcase
    end
`else
    assign lz_dark = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            shadow   <= 16'h0000;
            pend     <= 1'b0;
            pend_val <= 16'h0000;
            nibble_r <= 4'h0;
            t_r      <= ANODE_OFF;
            ack_r    <= 1'b0;
        end else begin
            if (tick) begin
                idx <= idx + 2'd1;
            end

            // The tick cycle forces one clock of dead time between digits.
            nibble_r <= shadow[{idx, 2'b00} +: 4];
            t_r      <= (bus.blank || tick || lz_dark) ? ANODE_OFF : anode_sel(idx);
            ack_r    <= commit;

            if (commit) begin
                shadow <= pend_val;
                pend   <= 1'b0;
            end

            // A load in the commit cycle wins over the clear and becomes the next pending value.
            if (bus.load) begin
                pend_val <= bus.value;
                pend     <= 1'b1;
            end
        end
    end

    assign bus.nibble   = nibble_r;
    assign bus.T        = t_r;
    assign bus.load_ack = ack_r;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with DIV = 4 (CLK_HZ = 8, SCAN_HZ = 2).
module tb_seg_scan_mux;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    typedef struct {
        logic [3:0] nib;
        logic [3:0] t;
        logic       ack;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_mux_if bus();

    seg_scan_mux #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          acks_seen = 0;
    int          acks_exp = 0;

    // Reference model: frame position derived from cycles since reset release.
    int          c = 0;
    logic [15:0] disp = 16'h0000;
    logic [15:0] pval = 16'h0000;
    bit          pend = 1'b0;

    task automatic step(input bit r, input bit ld, input logic [15:0] v, input bit bl);
        exp_t e;
        int   p, slot;
        bit   tk, dark;
        rst       = r;
        bus.load  = ld;
        bus.value = v;
        bus.blank = bl;
        if (r) begin
            e.nib = 4'h0; e.t = 4'hF; e.ack = 1'b0;
            c = 0; disp = 16'h0000; pend = 1'b0; pval = 16'h0000;
        end else begin
            p    = c % FRAME;
            slot = p / DIV;
            tk   = (p % DIV) == DIV - 1;
            dark = 1'b0;
`ifdef SEG_SCAN_MUX_LZB_EN
            if (slot > 0 && (disp >> (4 * slot)) == 16'h0000) dark = 1'b1;
`endif
            e.nib = 4'((disp >> (4 * slot)) & 16'h000F);
            e.t   = (bl || tk || dark) ? 4'hF : 4'(~(4'b0001 << slot));
            e.ack = tk && (slot == 3) && pend;
            if (e.ack) begin
                disp = pval;
                pend = 1'b0;
            end
            if (ld) begin
                pval = v;
                pend = 1'b1;
            end
            c++;
        end
        if (e.ack) acks_exp++;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit bl);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, bl);
    endtask

    task automatic load_now(input logic [15:0] v);
        step(1'b0, 1'b1, v, 1'b0);
    endtask

    task automatic align(input int pos);
        for (int i = 0; i < FRAME && (c % FRAME) != pos; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.load_ack === 1'b1) acks_seen++;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (bus.nibble !== e.nib || bus.T !== e.t || bus.load_ack !== e.ack) begin
                fails++;
                $display("FAIL outputs @%0t: got nibble=%h T=%b ack=%b, expected nibble=%h T=%b ack=%b",
                         $time, bus.nibble, bus.T, bus.load_ack, e.nib, e.t, e.ack);
            end
        end
    end

    initial begin
        int wait_cnt;
        rst = 1'b1; bus.load = 1'b0; bus.value = 16'h0000; bus.blank = 1'b0;

        // Reset and free-running scan of zero.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        idx_scan: begin
            idle(5, 1'b0);
        end

        // Load during slot 1; commit at frame end.
        load_now(16'hBEEF);
        idle(2 * FRAME, 1'b0);

        // Two loads in one frame: last wins, one ack.
        align(2);
        load_now(16'h1234);
        idle(1, 1'b0);
        load_now(16'h5678);
        idle(2 * FRAME, 1'b0);

        // Load coinciding with a commit tick.
        align(4);
        load_now(16'hA5C3);
        align(FRAME - 1);
        load_now(16'h0F1E);
        idle(2 * FRAME + 3, 1'b0);

        // Blank window with a load inside it.
        align(6);
        idle(9, 1'b1);
        step(1'b0, 1'b1, 16'hC0DE, 1'b1);
        idle(10, 1'b1);
        idle(2 * FRAME, 1'b0);

        // Reset mid-frame with a pending value.
        align(5);
        load_now(16'hDEAD);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Leading-zero patterns.
        load_now(16'h00A0);
        idle(2 * FRAME, 1'b0);
        load_now(16'h0000);
        idle(2 * FRAME, 1'b0);
        load_now(16'h0305);
        idle(2 * FRAME, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit r, ld, bl;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 9) == 0);
            bl = ($urandom_range(0, 7) == 0);
            step(r, ld, 16'($urandom), bl);
        end
        idle(FRAME, 1'b0);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        tests++;
        if (acks_seen != acks_exp) begin
            fails++;
            $display("FAIL ack_count: saw %0d acks, required %0d", acks_seen, acks_exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
